// File: rtl/ring_domain_queue.sv
// Domain-labelled normal queue fronting a ring-router input port.
// Control owns head/tail/count; messages live in a 1R/1W register file.

module ring_domain_queue_rf #(
  parameter int unsigned p_data_nbits  = 8,
  parameter int unsigned p_num_entries = 4,
  parameter int unsigned p_addr_nbits  = $clog2(p_num_entries)
)(
  input  logic                    clk,
  input  logic [p_addr_nbits-1:0] read_addr,
  output logic [p_data_nbits-1:0] read_data,
  input  logic                    write_en,
  input  logic [p_addr_nbits-1:0] write_addr,
  input  logic [p_data_nbits-1:0] write_data
);

  logic [p_data_nbits-1:0] r_mem [p_num_entries];

  always_ff @(posedge clk) begin
    if (write_en) r_mem[write_addr] <= write_data;
  end

  assign read_data = r_mem[read_addr];

endmodule

module ring_domain_queue #(
  parameter  int unsigned p_msg_nbits   = 8,
  parameter  int unsigned p_num_entries = 4,
  localparam int unsigned c_addr_nbits  = $clog2(p_num_entries)
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   domain,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg,
  output logic [c_addr_nbits:0]  num_free_entries
);

  localparam logic [c_addr_nbits:0]   c_num  = (c_addr_nbits+1)'(p_num_entries);
  localparam logic [c_addr_nbits-1:0] c_last = c_addr_nbits'(p_num_entries - 1);

  logic [c_addr_nbits-1:0] r_enq_ptr;
  logic [c_addr_nbits-1:0] r_deq_ptr;
  logic [c_addr_nbits:0]   r_count;
  logic                    r_domain;

  logic w_full;
  logic w_empty;
  logic w_flush;
  logic w_enq_fire;
  logic w_deq_fire;

  // Explicit wrap so non-power-of-two depths never touch addresses past the last entry.
  function automatic logic [c_addr_nbits-1:0] f_inc(input logic [c_addr_nbits-1:0] ptr);
    return (ptr == c_last) ? '0 : ptr + 1'b1;
  endfunction

  assign w_full     = (r_count == c_num);
  assign w_empty    = (r_count == '0);
  assign w_flush    = (domain != r_domain);

  assign enq_rdy    = reset & ~w_full  & ~w_flush;
  assign deq_val    = reset & ~w_empty & ~w_flush;
  assign w_enq_fire = enq_val & enq_rdy;
  assign w_deq_fire = deq_val & deq_rdy;

  assign num_free_entries = reset ? (c_num - r_count) : c_num;

  always_ff @(posedge clk) begin
    if (!reset || w_flush) begin
      r_enq_ptr <= '0;
      r_deq_ptr <= '0;
      r_count   <= '0;
      r_domain  <= domain;
    end else begin
      if (w_enq_fire) r_enq_ptr <= f_inc(r_enq_ptr);
      if (w_deq_fire) r_deq_ptr <= f_inc(r_deq_ptr);
      case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  ring_domain_queue_rf #(
    .p_data_nbits  (p_msg_nbits),
    .p_num_entries (p_num_entries),
    .p_addr_nbits  (c_addr_nbits)
  ) u_rf (
    .clk        (clk),
    .read_addr  (r_deq_ptr),
    .read_data  (deq_msg),
    .write_en   (w_enq_fire),
    .write_addr (r_enq_ptr),
    .write_data (enq_msg)
  );

endmodule
